// File: rtl/time_set_controller.sv
// time_set_controller: button-driven hh:mm:ss set sequencer; optional INC auto-repeat via TIME_SET_AUTOREPEAT_EN
module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int BLINK_CYCLES    = 8,
  parameter int REPEAT_CYCLES   = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_mode_btn,
  input  logic       i_inc_btn,
  input  logic [4:0] i_cur_hh,
  input  logic [5:0] i_cur_mm,
  input  logic [5:0] i_cur_ss,
  output logic [4:0] o_set_hh,
  output logic [5:0] o_set_mm,
  output logic [5:0] o_set_ss,
  output logic       o_load,
  output logic       o_setting,
  output logic [1:0] o_field,
  output logic       o_blink
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SET_HH, SET_MM, SET_SS, COMMIT} state_t;
  state_t state, state_nxt;
  logic [1:0] s1, s2, acc, acc_d;
  logic [DW-1:0] dcnt [2];
  logic [TW-1:0] tmo;
  logic [BW-1:0] bcnt;
  logic mode_ev, inc_ev, inc_go, in_set, nxt_set, to;
  assign mode_ev = acc[0] & ~acc_d[0];
  assign inc_ev  = acc[1] & ~acc_d[1];
  assign in_set  = state inside {SET_HH, SET_MM, SET_SS};
  assign nxt_set = state_nxt inside {SET_HH, SET_MM, SET_SS};
  assign to      = tmo == TW'(TIMEOUT_CYCLES);
  // synchronize, debounce and remember the previous accepted level of both buttons
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
      acc <= '0;
      acc_d <= '0;
      dcnt <= '{default: '0};
    end else begin
      s1 <= {i_inc_btn, i_mode_btn};
      s2 <= s1;
      acc_d <= acc;
      for (int i = 0; i < 2; i++)
        if (s2[i] == acc[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          acc[i] <= s2[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
    end
`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RW = $clog2(4 * REPEAT_CYCLES + 1);
  logic [RW-1:0] rcnt;
  logic rep_ev;
  assign rep_ev = in_set && acc[1] && !inc_ev && rcnt == RW'(4 * REPEAT_CYCLES - 1);
  assign inc_go = inc_ev | rep_ev;
  // hold-time counter: first repeat after 4 periods, then one per period
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rcnt <= '0;
    else rcnt <= (!in_set || !acc[1] || inc_ev) ? '0 : rep_ev ? RW'(3 * REPEAT_CYCLES) : rcnt + 1'b1;
`else
  assign inc_go = inc_ev;
`endif
  // idle watchdog while editing; any press restarts it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) tmo <= '0;
    else tmo <= (!in_set || mode_ev || inc_go) ? '0 : tmo + 1'b1;
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: mode advances, timeout abandons the edit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = mode_ev ? SET_HH : IDLE;
      SET_HH:  state_nxt = mode_ev ? SET_MM : to ? IDLE : SET_HH;
      SET_MM:  state_nxt = mode_ev ? SET_SS : to ? IDLE : SET_MM;
      SET_SS:  state_nxt = mode_ev ? COMMIT : to ? IDLE : SET_SS;
      default: state_nxt = IDLE;
    endcase
  end
  // Moore outputs decoded straight from the state register
  always_comb begin
    o_setting = in_set;
    o_load    = state == COMMIT;
    o_field   = state == SET_HH ? 2'b01 : state == SET_MM ? 2'b10 : state == SET_SS ? 2'b11 : 2'b00;
  end
  // shadow fields: sanitized capture on entry, wrapping increment of the selected field
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_set_hh <= '0;
      o_set_mm <= '0;
      o_set_ss <= '0;
    end else if (state == IDLE && mode_ev) begin
      o_set_hh <= i_cur_hh > 5'd23 ? '0 : i_cur_hh;
      o_set_mm <= i_cur_mm > 6'd59 ? '0 : i_cur_mm;
      o_set_ss <= i_cur_ss > 6'd59 ? '0 : i_cur_ss;
    end else if (in_set && inc_go && !mode_ev) begin
      if (state == SET_HH) o_set_hh <= o_set_hh == 5'd23 ? '0 : o_set_hh + 1'b1;
      if (state == SET_MM) o_set_mm <= o_set_mm == 6'd59 ? '0 : o_set_mm + 1'b1;
      if (state == SET_SS) o_set_ss <= o_set_ss == 6'd59 ? '0 : o_set_ss + 1'b1;
    end
  // blink phase restarts high on every state change and toggles each half-period while editing
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      bcnt <= '0;
      o_blink <= 1'b0;
    end else if (state_nxt != state) begin
      bcnt <= '0;
      o_blink <= nxt_set;
    end else if (in_set) begin
      bcnt <= bcnt == BW'(BLINK_CYCLES - 1) ? '0 : bcnt + 1'b1;
      o_blink <= bcnt == BW'(BLINK_CYCLES - 1) ? ~o_blink : o_blink;
    end else begin
      bcnt <= '0;
      o_blink <= 1'b0;
    end
endmodule
